rv_mem_resp: RTL and testbench
==============================

// Module: rv_mem_resp
// PURPOSE
//   Memory-side responder for the multicycle RISC-V core's load/store interface.
//   Accepts one word request at a time (read or write) through a req/gnt handshake.
//   Holds a word-organised RAM and returns a one-cycle rvalid pulse after a
//   programmable number of wait cycles.
//   Sits between the core's memory port and the backing storage. It lets the control
//   FSM be exercised against a slow memory instead of a zero-latency one.
// PARAMETERS
//   DEPTH    1024  number of 32-bit words in the RAM; must be a power of two, >= 2
//   LATENCY  2     wait cycles inserted between accept and response; range 0..15
// PORTS
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous, active-low reset
//   req     in   1   request valid from core
//   we      in   1   1 = write (store), 0 = read (load); sampled with req
//   addr    in   32  byte address; word index = addr[$clog2(DEPTH)+1:2]
//   wdata   in   32  store data; sampled with req
//   gnt     out  1   responder can accept a request this cycle
//   rvalid  out  1   one-cycle pulse: request completed
//   rdata   out  32  read data; valid while rvalid=1 for a read
//   busy    out  1   a request is in progress (state != IDLE)
//   err     out  1   error flag, qualified by rvalid (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE, gnt=1, rvalid=0, rdata=0, err=0, busy=0,
//   wait counter=0. RAM contents are not reset.
// - FSM states: IDLE, WAIT, RESP.
//   - IDLE: gnt=1. On req&gnt, capture we, word index, wdata and error status.
//     Go to RESP if LATENCY==0; otherwise go to WAIT and load counter=LATENCY-1.
//   - WAIT: gnt=0. Decrement counter; go to RESP when counter==0.
//   - RESP: gnt=0, rvalid=1 for exactly one cycle, then return to IDLE.
// - Latency: rvalid rises LATENCY+1 cycles after the accepting clock edge.
// - Throughput: one request per LATENCY+2 cycles. A req held high through RESP is
//   accepted again on the first IDLE cycle after it.
// - Writes commit to the RAM on the clock edge that leaves RESP.
//   - rdata is unchanged by a write.
// - Reads: rdata is registered from RAM[index] on entry to RESP.
//   - rdata holds its value until the next read response.
// - A read in a later request returns data from an earlier completed write to the
//   same index: write-before-read, no bypass needed.
// - req, we, addr and wdata are ignored outside IDLE; they may change freely.
// - Reset asserted mid-operation drops the pending request. A pending write is not
//   committed and no rvalid is issued.
// - Address index width is $clog2(DEPTH). Upper address bits and addr[1:0] are
//   ignored unless MEM_ERR_EN is defined; addresses wrap modulo DEPTH*4.
// CONFIGURATION
//   MEM_ERR_EN defined:
//   - At accept, an error is flagged if addr[1:0]!=0 or addr >= DEPTH*4.
//   - On an error, err=1 in the RESP cycle, together with rvalid.
//   - An erroring write is not committed; an erroring read drives rdata=0.
//   - Timing is identical to a non-erroring request.
//   MEM_ERR_EN undefined:
//   - err is tied to 0 and no address checks are made.
//   - Addresses wrap as described above.
// TESTING
// 1. Reset then idle: gnt=1, busy=0, rvalid=0, rdata=0 for 5 cycles; req=0.
// 2. Write addr=0x10, wdata=0xCAFEF00D (LATENCY=2):
//    - rvalid pulses exactly 3 cycles after accept.
//    - A later read of 0x10 returns 0xCAFEF00D with rvalid.
// 3. req held high across two reads: second accept occurs on the cycle after RESP;
//    gnt=0 during WAIT/RESP; responses are spaced exactly 4 cycles apart.
// 4. Assert rst_n=0 during WAIT of a write to 0x20 (old value 0x11111111):
//    - No rvalid is issued.
//    - After reset, a read of 0x20 returns 0x11111111.
// 5. MEM_ERR_EN defined, DEPTH=1024:
//    - Read 0x1002 -> rvalid=1, err=1, rdata=0.
//    - Write to 0x1000 (4096) -> err=1 and RAM unchanged.
//    - Undefined build: write 0x1000 lands at index 0.
// 6. LATENCY=0: rvalid pulses 1 cycle after accept; back-to-back requests every 2
//    cycles.

Source files
------------

// File: rtl/rv_mem_resp_if.sv
// rv_mem_resp_if: request/response bundle between the core's load/store port
// (master) and the memory responder (slave).
//   req, we, addr[31:0], wdata[31:0]       master -> slave
//   gnt, rvalid, rdata[31:0], busy, err    slave  -> master
interface rv_mem_resp_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        busy;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, busy, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, busy, err
    );
endinterface

// File: rtl/rv_mem_resp.sv
// rv_mem_resp: memory-side responder for the multicycle core. Accepts one word
// request at a time, waits LATENCY cycles, then pulses rvalid for one cycle.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rv_mem_resp_if.slave (req/we/addr/wdata in; gnt/rvalid/rdata/busy/err out)
// Parameters: DEPTH (words, power of two >= 2), LATENCY (0..15 wait cycles).
// Optional feature macro MEM_ERR_EN: flags misaligned or out-of-range addresses
// through err; without it err is tied low and addresses wrap modulo DEPTH*4.
module rv_mem_resp #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    rv_mem_resp_if.slave  bus
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAT_M1 = (LATENCY == 0) ? '0 : CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            we_q;
    logic [IW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic            err_q;

    logic            gnt_q;
    logic            busy_q;
    logic            rvalid_q;
    logic [31:0]     rdata_q;

    logic [31:0]     ram [DEPTH];

    logic            accept_c;
    logic            enter_resp_c;
    logic            addr_err_c;
    logic [IW-1:0]   idx_in_c;
    logic            resp_we_c;
    logic [IW-1:0]   resp_idx_c;
    logic            resp_err_c;

    // Address bits outside the word index only matter to the error check.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[31:IW+2], bus.addr[1:0]};

    assign idx_in_c = bus.addr[IW+1:2];
    assign accept_c = (state_q == S_IDLE) && bus.req;

`ifdef MEM_ERR_EN
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;
    assign addr_err_c = (bus.addr[1:0] != 2'b00) || ({1'b0, bus.addr} >= ADDR_LIMIT);
`else
    assign addr_err_c = 1'b0;
`endif

    // With LATENCY==0 RESP is entered straight from IDLE, before the request
    // has been captured, so take its attributes from the bus in that case.
    assign resp_we_c  = (state_q == S_IDLE) ? bus.we     : we_q;
    assign resp_idx_c = (state_q == S_IDLE) ? idx_in_c   : idx_q;
    assign resp_err_c = (state_q == S_IDLE) ? addr_err_c : err_q;

    assign enter_resp_c = (state_d == S_RESP) && (state_q != S_RESP);

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    cnt_d   = LAT_M1;
                    state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            gnt_q    <= 1'b1;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_q    <= (state_d == S_IDLE);
            busy_q   <= (state_d != S_IDLE);
            rvalid_q <= (state_d == S_RESP);
            if (accept_c) begin
                we_q    <= bus.we;
                idx_q   <= idx_in_c;
                wdata_q <= bus.wdata;
                err_q   <= addr_err_c;
            end
            if (enter_resp_c && !resp_we_c) begin
                rdata_q <= resp_err_c ? '0 : ram[resp_idx_c];
            end
        end
    end

    // Writes commit on the edge leaving RESP; an async reset before then
    // returns state_q to IDLE and the write is dropped.
    always_ff @(posedge clk) begin
        if ((state_q == S_RESP) && we_q && !err_q) begin
            ram[idx_q] <= wdata_q;
        end
    end

`ifdef MEM_ERR_EN
    logic err_o_q;

    // err accompanies rvalid only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o_q <= 1'b0;
        end else begin
            err_o_q <= (state_d == S_RESP) && resp_err_c;
        end
    end

    assign bus.err = err_o_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.gnt    = gnt_q;
    assign bus.busy   = busy_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_rv_mem_resp.sv
// tb_rv_mem_resp: self-checking bench for rv_mem_resp. Main instance uses
// DEPTH=1024/LATENCY=2; a second small instance exercises LATENCY=0.
module tb_rv_mem_resp;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
`ifdef MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    rv_mem_resp_if bus();
    rv_mem_resp_if bus0();

    rv_mem_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    rv_mem_resp #(.DEPTH(16), .LATENCY(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mem_m [DEPTH];
    logic [31:0] last_rd;

    function automatic logic model_err(input logic [31:0] a);
        if (!ERR_EN) return 1'b0;
        return (a % 4 != 0) || (64'(a) >= 64'(DEPTH) * 4);
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    // Applies one request to the model; returns the response it should give.
    task automatic model_apply(input logic w, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] exp_rd, output logic exp_e);
        exp_e = model_err(a);
        if (w) begin
            exp_rd = last_rd;
            if (!exp_e) mem_m[model_idx(a)] = d;
        end else begin
            exp_rd  = exp_e ? 32'h0 : mem_m[model_idx(a)];
            last_rd = exp_rd;
        end
    endtask

    // ---------------- driver (main instance) ----------------
    // Called at a negedge while the DUT is idle; returns at the negedge of the
    // idle cycle that follows the response.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e, output int lat, output bit ok);
        int g;
        ok  = 1'b1;
        lat = 0;
        rd  = 'x;
        e   = 1'bx;
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        g = 0;
        while (!bus.gnt && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!bus.gnt) begin
            ok = 1'b0;
            bus.req = 1'b0;
            return;
        end
        @(negedge clk);
        lat = 1;
        while (!bus.rvalid && lat < 40) begin
            bus.req = 1'b0; bus.we = 1'($urandom); bus.addr = $urandom; bus.wdata = $urandom;
            if (bus.gnt || !bus.busy) ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        bus.req = 1'b0;
        rd = bus.rdata;
        e  = bus.err;
        if (bus.gnt || !bus.busy) ok = 1'b0;
        @(negedge clk);
        if (bus.rvalid || !bus.gnt || bus.busy) ok = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_rd;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] rd, exp_rd;
    logic        e, exp_e;
    int          lat;
    bit          ok;
    int          bad_fill;
    int          acc [2];
    int          rsp [2];
    logic [31:0] rsp_d [2];
    int          na, nr, gnt_low, rv_seen;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
        last_rd = '0;
        for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 32'h5A00_0000 | 32'(i);

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({bus.gnt, bus.busy, bus.rvalid, bus.err, bus.rdata}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));
        rst_n = 1'b1;

        // Idle after reset with req low.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("idle_outputs", 64'({bus.gnt, bus.busy, bus.rvalid, bus.err, bus.rdata}),
                  64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));
        end

        // Fill the RAM with a known pattern.
        bad_fill = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            do_req(1'b1, 32'(i) * 4, 32'h5A00_0000 | 32'(i), rd, e, lat, ok);
            if (!ok || lat != int'(LAT) + 1 || e !== 1'b0 || rd !== 32'h0) bad_fill++;
        end
        check("fill_handshakes", 64'(bad_fill), 64'(0));

        // Directed table.
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0020, 32'h0, 1'b1, 32'h1111_1111, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 1'b0, 32'h0, ERR_EN};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0, 1'b1,
                     ERR_EN ? 32'h5A00_0000 : 32'h1234_5678, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_1002, 32'h0, 1'b1,
                     ERR_EN ? 32'h0 : 32'h1234_5678, ERR_EN};
        vecs[7]  = '{1'b0, 32'h0000_0FFC, 32'h0, 1'b1, 32'h5A00_03FF, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0013, 32'hAAAA_5555, 1'b0, 32'h0, ERR_EN};
        vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0, 1'b1,
                     ERR_EN ? 32'hCAFE_F00D : 32'hAAAA_5555, 1'b0};
        vecs[10] = '{1'b1, 32'hFFFF_FFFC, 32'hBBBB_0000, 1'b0, 32'h0, ERR_EN};
        vecs[11] = '{1'b0, 32'h0000_0FFC, 32'h0, 1'b1,
                     ERR_EN ? 32'h5A00_03FF : 32'hBBBB_0000, 1'b0};

        for (int v = 0; v < 12; v++) begin
            do_req(vecs[v].we, vecs[v].addr, vecs[v].wdata, rd, e, lat, ok);
            check($sformatf("vec%0d_latency", v), 64'(lat), 64'(LAT + 1));
            check($sformatf("vec%0d_handshake", v), 64'(ok), 64'(1));
            check($sformatf("vec%0d_err", v), 64'(e), 64'(vecs[v].err));
            if (vecs[v].chk_rd) check($sformatf("vec%0d_rdata", v), 64'(rd), 64'(vecs[v].rdata));
            model_apply(vecs[v].we, vecs[v].addr, vecs[v].wdata, exp_rd, exp_e);
        end

        // Reset during WAIT of a write to 0x20: write dropped, no rvalid.
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h20; bus.wdata = 32'hDEAD_BEEF;
        check("rst_wr_gnt", 64'(bus.gnt), 64'(1));
        @(negedge clk);
        bus.req = 1'b0;
        check("rst_wr_in_wait", 64'({bus.busy, bus.gnt}), 64'({1'b1, 1'b0}));
        rst_n = 1'b0;
        #1;
        check("rst_async", 64'({bus.gnt, bus.busy, bus.rvalid, bus.rdata}),
              64'({1'b1, 1'b0, 1'b0, 32'h0}));
        rv_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.rvalid) rv_seen++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.rvalid) rv_seen++;
        end
        check("rst_no_rvalid", 64'(rv_seen), 64'(0));
        last_rd = 32'h0;
        do_req(1'b0, 32'h20, 32'h0, rd, e, lat, ok);
        check("rst_read_back", 64'(rd), 64'(32'h1111_1111));
        model_apply(1'b0, 32'h20, 32'h0, exp_rd, exp_e);

        // req held high across two reads.
        exp_rd = mem_m[4];
        acc = '{-1, -1}; rsp = '{-1, -1}; na = 0; nr = 0; gnt_low = 0;
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h10;
        for (int c = 0; c < 30 && nr < 2; c++) begin
            if (bus.gnt && na < 2) acc[na++] = c;
            if (!bus.gnt) gnt_low++;
            if (bus.rvalid) begin
                rsp_d[nr] = bus.rdata;
                rsp[nr++] = c;
                if (nr == 2) bus.req = 1'b0;
            end
            @(negedge clk);
        end
        bus.req = 1'b0;
        check("b2b_first_latency", 64'(rsp[0] - acc[0]), 64'(LAT + 1));
        check("b2b_second_accept", 64'(acc[1] - rsp[0]), 64'(1));
        check("b2b_spacing", 64'(rsp[1] - rsp[0]), 64'(LAT + 2));
        check("b2b_gnt_low", 64'(gnt_low), 64'(2 * (LAT + 1)));
        check("b2b_rdata0", 64'(rsp_d[0]), 64'(exp_rd));
        check("b2b_rdata1", 64'(rsp_d[1]), 64'(exp_rd));
        last_rd = exp_rd;

        // Randomized traffic against the model.
        for (int t = 0; t < 400; t++) begin
            logic        w;
            logic [31:0] a, d;
            w = 1'($urandom);
            a = ($urandom_range(0, 9) < 7) ? 32'($urandom_range(0, DEPTH - 1)) * 4 : $urandom;
            d = $urandom;
            model_apply(w, a, d, exp_rd, exp_e);
            do_req(w, a, d, rd, e, lat, ok);
            check($sformatf("rnd%0d_latency", t), 64'(lat), 64'(LAT + 1));
            check($sformatf("rnd%0d_handshake", t), 64'(ok), 64'(1));
            check($sformatf("rnd%0d_rdata a=%h w=%0d", t, a, w), 64'(rd), 64'(exp_rd));
            check($sformatf("rnd%0d_err a=%h", t, a), 64'(e), 64'(exp_e));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // LATENCY=0 instance: held req gives a response every 2 cycles.
        acc = '{-1, -1}; rsp = '{-1, -1}; na = 0; nr = 0;
        bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 32'h8; bus0.wdata = 32'hBEEF_0008;
        for (int c = 0; c < 20 && nr < 2; c++) begin
            if (bus0.gnt && na < 2) acc[na++] = c;
            if (bus0.rvalid) begin
                rsp[nr++] = c;
                if (nr == 2) bus0.req = 1'b0;
            end
            @(negedge clk);
        end
        bus0.req = 1'b0;
        check("lat0_latency", 64'(rsp[0] - acc[0]), 64'(1));
        check("lat0_spacing", 64'(rsp[1] - rsp[0]), 64'(2));
        check("lat0_second_accept", 64'(acc[1] - rsp[0]), 64'(1));
        @(negedge clk);
        bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'h8;
        check("lat0_rd_gnt", 64'(bus0.gnt), 64'(1));
        @(negedge clk);
        bus0.req = 1'b0;
        check("lat0_rd_resp", 64'({bus0.rvalid, bus0.err, bus0.rdata}),
              64'({1'b1, 1'b0, 32'hBEEF_0008}));
        @(negedge clk);
        check("lat0_pulse_end", 64'({bus0.rvalid, bus0.gnt}), 64'({1'b0, 1'b1}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
